tw27_addr_seq: RTL and testbench

//  Twiddle-address sequencer for the 27-point DFT inter-stage twiddle multiply.

---
 rtl/tw27_addr_seq.sv | 156 +++++++++++++++
 tb/tb_tw27_addr_seq.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/tw27_addr_seq.sv
// Twiddle-address sequencer for the 27-point DFT inter-stage twiddle multiply (e = k1*n2).
// Define TW27_INV_EN to enable the inverse-DFT address path selected by the latched inv input.
module tw27_addr_seq #(
  parameter int ORDER = 0,
  parameter int TW_FF = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       cont,
  input  logic       di_en,
  input  logic       inv,
  output logic [4:0] tw_addr,
  output logic       tw_dv,
  output logic       tw_last,
  output logic       busy,
  output logic       err
);

  localparam logic [3:0] N2_MAX = (ORDER == 0) ? 4'd8 : 4'd2;

  typedef enum logic {IDLE, RUN} state_t;

  state_t     state_q, state_d;
  logic [4:0] idx_q, idx_d, e_q, e_d, tw_addr_q, tw_addr_d;
  logic [3:0] k1_q, k1_d, n2_q, n2_d;
  logic       tw_vld_q, tw_vld_d, last_q, last_d, err_q, err_d;
  logic       accept;
  logic [4:0] idx_c, e_c, addr_c;
  logic [3:0] k1_c, n2_c;

  // A start in the same cycle as di_en makes that sample index 0 of the new frame.
  assign idx_c = start ? 5'd0 : idx_q;
  assign e_c   = start ? 5'd0 : e_q;
  assign k1_c  = start ? 4'd0 : k1_q;
  assign n2_c  = start ? 4'd0 : n2_q;

`ifdef TW27_INV_EN
  logic inv_q, inv_d;
  assign inv_d  = start ? inv : inv_q;
  assign addr_c = (inv_d && (e_c != 5'd0)) ? (5'd27 - e_c) : e_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) inv_q <= 1'b0;
    else     inv_q <= inv_d;
  end
`else
  logic unused_inv;
  assign unused_inv = inv;
  assign addr_c     = e_c;
`endif

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_c;
    e_d       = e_c;
    k1_d      = k1_c;
    n2_d      = n2_c;
    err_d     = err_q;
    tw_addr_d = tw_addr_q;
    tw_vld_d  = 1'b0;
    last_d    = 1'b0;
    accept    = di_en & ((state_q == RUN) | start);

    if (start) begin
      state_d = RUN;
      err_d   = 1'b0;
    end else if ((state_q == IDLE) && di_en) begin
      err_d = 1'b1;
    end

    if (accept) begin
      tw_vld_d  = 1'b1;
      tw_addr_d = addr_c;
      last_d    = (idx_c == 5'd26);
      if (idx_c == 5'd26) begin
        idx_d = 5'd0;
        k1_d  = 4'd0;
        n2_d  = 4'd0;
        e_d   = 5'd0;
        if (!cont && !start) state_d = IDLE;
      end else begin
        idx_d = idx_c + 5'd1;
        if (n2_c == N2_MAX) begin
          n2_d = 4'd0;
          k1_d = k1_c + 4'd1;
          e_d  = 5'd0;
        end else begin
          // Incremental k1*n2; peaks at 16 so no modulo is needed.
          n2_d = n2_c + 4'd1;
          e_d  = e_c + {1'b0, k1_c};
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= 5'd0;
      e_q       <= 5'd0;
      k1_q      <= 4'd0;
      n2_q      <= 4'd0;
      tw_addr_q <= 5'd0;
      tw_vld_q  <= 1'b0;
      last_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      e_q       <= e_d;
      k1_q      <= k1_d;
      n2_q      <= n2_d;
      tw_addr_q <= tw_addr_d;
      tw_vld_q  <= tw_vld_d;
      last_q    <= last_d;
      err_q     <= err_d;
    end
  end

  // Strobes are delayed to line up with the ROM output register(s).
  generate
    if (TW_FF == 0) begin : g_no_dly
      assign tw_dv   = tw_vld_q;
      assign tw_last = last_q;
    end else begin : g_dly
      logic [TW_FF-1:0] dv_sr_q, dv_sr_d, last_sr_q, last_sr_d;
      genvar gi;
      for (gi = 0; gi < TW_FF; gi++) begin : g_stage
        if (gi == 0) begin : g_first
          assign dv_sr_d[gi]   = tw_vld_q;
          assign last_sr_d[gi] = last_q;
        end else begin : g_next
          assign dv_sr_d[gi]   = dv_sr_q[gi-1];
          assign last_sr_d[gi] = last_sr_q[gi-1];
        end
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            dv_sr_q[gi]   <= 1'b0;
            last_sr_q[gi] <= 1'b0;
          end else begin
            dv_sr_q[gi]   <= dv_sr_d[gi];
            last_sr_q[gi] <= last_sr_d[gi];
          end
        end
      end
      assign tw_dv   = dv_sr_q[TW_FF-1];
      assign tw_last = last_sr_q[TW_FF-1];
    end
  endgenerate

  assign tw_addr = tw_addr_q;
  assign busy    = (state_q == RUN);
  assign err     = err_q;

endmodule

// File: tb/tb_tw27_addr_seq.sv
// Bench for tw27_addr_seq: two instances (3x9 / no ROM delay, 9x3 / one-cycle ROM delay)
// driven in parallel and compared against a frame-position reference model.
module tb_tw27_addr_seq;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0, cont = 1'b0, di_en = 1'b0, inv = 1'b0;

  logic [4:0] a0, a1;
  logic dv0, dv1, l0, l1, b0, b1, e0, e1;

  always #5 clk = ~clk;

  tw27_addr_seq #(.ORDER(0), .TW_FF(0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .cont(cont), .di_en(di_en), .inv(inv),
    .tw_addr(a0), .tw_dv(dv0), .tw_last(l0), .busy(b0), .err(e0));

  tw27_addr_seq #(.ORDER(1), .TW_FF(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .cont(cont), .di_en(di_en), .inv(inv),
    .tw_addr(a1), .tw_dv(dv1), .tw_last(l1), .busy(b1), .err(e1));

  // reference model state
  int run_m, pos_m, err_m, inv_m;
  int addr_m [2];
  int vld1_m, last1_m, dvd_m, lastd_m;
  int n_total = 0, n_pass = 0;

  function automatic int exp_addr(input int order, input int p, input int iv);
    int k1, n2, e;
    k1 = (order == 0) ? p / 9 : p / 3;
    n2 = (order == 0) ? p % 9 : p % 3;
    e  = k1 * n2;
`ifdef TW27_INV_EN
    if (iv != 0) e = (27 - e) % 27;
`else
    if (iv != 0) e = e + 0;
`endif
    return e;
  endfunction

  task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d at t=%0t", tag, obs, exp, $time);
  endtask

  task automatic check_all();
    chk("addr0", a0, 5'(addr_m[0]));
    chk("dv0",   {4'd0, dv0}, 5'(vld1_m));
    chk("last0", {4'd0, l0},  5'(last1_m));
    chk("busy0", {4'd0, b0},  5'(run_m));
    chk("err0",  {4'd0, e0},  5'(err_m));
    chk("addr1", a1, 5'(addr_m[1]));
    chk("dv1",   {4'd0, dv1}, 5'(dvd_m));
    chk("last1", {4'd0, l1},  5'(lastd_m));
    chk("busy1", {4'd0, b1},  5'(run_m));
    chk("err1",  {4'd0, e1},  5'(err_m));
  endtask

  task automatic model_clear();
    run_m = 0; pos_m = 0; err_m = 0; inv_m = 0;
    addr_m[0] = 0; addr_m[1] = 0;
    vld1_m = 0; last1_m = 0; dvd_m = 0; lastd_m = 0;
  endtask

  // Reset is raised between edges so its asynchronous effect is visible before any edge.
  task automatic do_reset();
    start = 1'b0; cont = 1'b0; di_en = 1'b0; inv = 1'b0;
    rst = 1'b1;
    model_clear();
    #2;
    check_all();
    @(posedge clk); #1;
    rst = 1'b0;
    check_all();
  endtask

  task automatic step(input bit s, input bit c, input bit d, input bit i);
    int acc, p, nxt_run;
    start = s; cont = c; di_en = d; inv = i;
    acc = (d && (run_m != 0 || s)) ? 1 : 0;
    nxt_run = run_m;
    if (s) begin
      pos_m = 0; inv_m = i; err_m = 0; nxt_run = 1;
    end else if (d && run_m == 0) begin
      err_m = 1;
    end
    dvd_m = vld1_m;
    lastd_m = last1_m;
    vld1_m = acc;
    last1_m = 0;
    p = pos_m;
    if (acc != 0) begin
      addr_m[0] = exp_addr(0, p, inv_m);
      addr_m[1] = exp_addr(1, p, inv_m);
      last1_m = (p == 26) ? 1 : 0;
      if (p == 26 && !c && !s) nxt_run = 0;
      pos_m = (p + 1) % 27;
    end
    run_m = nxt_run;
    @(posedge clk); #1;
    if (acc != 0)
      $display("t=%0t sample %0d addr0=%0d addr1=%0d last=%0d", $time, p, a0, a1, l0);
    check_all();
  endtask

  initial begin
    int n;
    bit d;
    model_clear();
    #2;
    do_reset();

    // single frame, back to back, then tail cycles
    step(1, 0, 1, 0);
    for (int k = 1; k < 27; k++) step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    // inverse selection latched at start, inv toggled mid-frame
    step(1, 0, 1, 1);
    for (int k = 1; k < 27; k++) step(0, 0, 1, (k < 10) ? 1'b1 : 1'b0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    // di_en in idle sets err, start clears it
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    step(1, 1, 0, 0);

    // continuous mode: 54 samples with random gaps
    n = 0;
    while (n < 54) begin
      d = ($urandom_range(0, 2) != 0);
      step(0, !(d && n == 53), d, $urandom_range(0, 1));
      if (d) n++;
    end
    step(0, 0, 0, 0);

    // mid-frame restart after 10 samples, then a full frame
    step(1, 0, 1, 0);
    for (int k = 1; k < 10; k++) step(0, 0, 1, 0);
    step(1, 0, 0, 0);
    for (int k = 0; k < 27; k++) step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    // reset with a pending delayed strobe
    step(1, 0, 1, 0);
    for (int k = 1; k < 14; k++) step(0, 0, 1, 0);
    do_reset();
    step(0, 0, 0, 0);

    // random traffic
    for (int k = 0; k < 400; k++)
      step($urandom_range(0, 39) == 0, $urandom_range(0, 1), $urandom_range(0, 3) != 0,
           $urandom_range(0, 1));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
